// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit with HI/LO result registers. Multiplies and
// divides retire one bit per cycle (WIDTH iterations plus a fix-up cycle).
// MTHI/MTLO write HI/LO directly in one cycle.
//
// Configuration macro: MULDIV_DIV_EN
//   defined     : DIV/DIVU implemented (restoring shift-subtract)
//   not defined : divider omitted, op 010/011 behave as no-ops
//
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      asynchronous active-low reset, clears all state
//   start  in  1      request, sampled while busy=0
//   op     in  3      000 MULTU, 001 MULT, 010 DIVU, 011 DIV,
//                     100 MTHI, 101 MTLO, 11x no-op
//   a      in  WIDTH  multiplicand / dividend / MTHI-MTLO source
//   b      in  WIDTH  multiplier / divisor
//   busy   out 1      iterative operation in progress
//   done   out 1      one-cycle pulse when hi/lo take a mult/div result
//   hi     out WIDTH  product upper half / remainder
//   lo     out WIDTH  product lower half / quotient
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
`ifdef MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } state_t;

    state_t                 state_r, state_s;
    logic [CW-1:0]          cnt_r;
    logic [2*WIDTH-1:0]     acc_r, acc_next_s;
    logic [WIDTH-1:0]       opnd_r;        // |a| for multiply, |b| for divide
    logic                   neg_res_r;     // product / quotient must be negated
    logic [WIDTH:0]         mul_sum_s;
    logic [WIDTH-1:0]       res_hi_s, res_lo_s;
    logic [2*WIDTH-1:0]     prod_s;
    logic                   accept_s;
`ifdef MULDIV_DIV_EN
    logic                   op_div_r;
    logic                   neg_rem_r;     // remainder takes dividend sign
    logic                   b_zero_r;
    logic [WIDTH-1:0]       a_raw_r;       // dividend as presented, for div-by-zero
    logic [WIDTH:0]         rem_sh_s, div_diff_s;
`endif

    // Two's-complement magnitude; only signed operands are folded
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic signed_mode);
        if (signed_mode && v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    assign accept_s = (state_r == S_IDLE) && start && !op[2] && (!op[1] || DIV_EN);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: WIDTH iterations in CALC, then one fix-up cycle in FIN
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = accept_s ? S_CALC : S_IDLE;
            S_CALC:  state_s = (cnt_r == CNT_LAST) ? S_FIN : S_CALC;
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // One iteration step of the shared accumulator
    always_comb begin
        // Shift-add: accumulator is {partial product, unconsumed multiplier bits}
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        // Restoring divide: accumulator is {remainder, dividend/quotient bits}
        rem_sh_s   = acc_r[2*WIDTH-1:WIDTH-1];
        div_diff_s = rem_sh_s - {1'b0, opnd_r};
        if (op_div_r) begin
            if (!div_diff_s[WIDTH]) begin
                acc_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_next_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
`endif
    end

    // Operand latch at accept, iteration during CALC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            neg_res_r <= 1'b0;
`ifdef MULDIV_DIV_EN
            op_div_r  <= 1'b0;
            neg_rem_r <= 1'b0;
            b_zero_r  <= 1'b0;
            a_raw_r   <= {WIDTH{1'b0}};
`endif
        end else if (accept_s) begin
            cnt_r     <= {CW{1'b0}};
            neg_res_r <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            if (op[1]) begin
                acc_r  <= {{WIDTH{1'b0}}, magnitude(a, op[0])};
                opnd_r <= magnitude(b, op[0]);
            end else begin
                acc_r  <= {{WIDTH{1'b0}}, magnitude(b, op[0])};
                opnd_r <= magnitude(a, op[0]);
            end
`ifdef MULDIV_DIV_EN
            op_div_r  <= op[1];
            neg_rem_r <= op[0] & a[WIDTH-1];
            b_zero_r  <= (b == {WIDTH{1'b0}});
            a_raw_r   <= a;
`endif
        end else if (state_r == S_CALC) begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Sign fix-up of the finished accumulator
    always_comb begin
        prod_s   = neg_res_r ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        // MIN / -1 needs no special case: magnitude quotient 2^(W-1) negates to MIN
        if (op_div_r) begin
            if (b_zero_r) begin
                res_hi_s = a_raw_r;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = neg_res_r ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0])
                                     : acc_r[WIDTH-1:0];
                res_hi_s = neg_rem_r ? ({WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH])
                                     : acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
            res_lo_s = prod_s[WIDTH-1:0];
        end
`endif
    end

    // Registered outputs: HI/LO writes, busy and done flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            done <= 1'b0;
            hi   <= {WIDTH{1'b0}};
            lo   <= {WIDTH{1'b0}};
        end else begin
            done <= (state_r == S_FIN);
            if (accept_s) begin
                busy <= 1'b1;
            end else if (state_r == S_FIN) begin
                busy <= 1'b0;
            end
            if (state_r == S_FIN) begin
                hi <= res_hi_s;
                lo <= res_lo_s;
            end else if ((state_r == S_IDLE) && start && (op == 3'b100)) begin
                hi <= a;
            end else if ((state_r == S_IDLE) && start && (op == 3'b101)) begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Randomised plus directed bench for muldiv_unit. A transaction-level model
// (plain 64-bit arithmetic and a countdown to the result cycle) predicts
// busy/done/hi/lo; a compare process checks them on every falling edge.
// A second WIDTH=8 instance covers the parameterisation.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  a, b, hi, lo;
    logic          busy, done;

    logic          start8;
    logic [2:0]    op8;
    logic [7:0]    a8, b8, hi8, lo8;
    logic          busy8, done8;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
    );

    // Architectural result {hi, lo} of a mult/div from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: p = {32'd0, x} * {32'd0, y};
            3'd1: p = sx * sy;
            3'd2: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else            p = {x % y, x / y};
            end
            3'd3: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: accept rule and result timing at transaction level
    logic          m_busy, m_done;
    logic [W-1:0]  m_hi, m_lo;
    logic [63:0]   m_pend;
    int            m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
            m_pend <= '0;   m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_hi   <= m_pend[63:32];
                    m_lo   <= m_pend[31:0];
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
                m_left <= m_left - 1;
            end else if (start) begin
                if (!op[2] && (!op[1] || DIV_EN)) begin
                    m_pend <= ref_result(op, a, b);
                    m_busy <= 1'b1;
                    m_left <= W + 1;
                end else if (op == 3'b100) begin
                    m_hi <= a;
                end else if (op == 3'b101) begin
                    m_lo <= a;
                end
            end
        end
    end

    // Compare process: every falling edge
    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("hi",   hi,   m_hi);
        chk("lo",   lo,   m_lo);
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = $urandom; b = $urandom;   // operands must already be latched
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
        end
        if (n >= 100) chk("done_timeout", 64'(n), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    int n;

    initial begin
        reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
        start8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0;

        // Pin the model with hand-computed results
        chk("ref_multu", ref_result(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        chk("ref_mult",  ref_result(3'd1, 32'hFFFF_FFFD, 32'd5),         64'hFFFF_FFFF_FFFF_FFF1);
        chk("ref_div",   ref_result(3'd3, 32'hFFFF_FFF9, 32'd2),         64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_divu0", ref_result(3'd2, 32'd7, 32'd0),                 64'h0000_0007_FFFF_FFFF);
        chk("ref_ovf",   ref_result(3'd3, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        repeat (3) @(posedge clk);
        #2 reset = 1'b1;

        // Reset in the middle of a MULT clears everything
        issue(3'd4, 32'h55, 32'd0);
        issue(3'd1, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_hi",   hi,   32'd0);
        chk("rst_lo",   lo,   32'd0);
        reset = 1'b1;
        @(posedge clk);
        #2;
        issue(3'd5, 32'h1234_5678, 32'd0);
        chk("mtlo_lo",   lo,   32'h1234_5678);
        chk("mtlo_done", done, 1'b0);

        // Directed multiplies with latency
        issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n);
        chk("multu_lat", 64'(n), 64'd33);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        wait_done(n);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

`ifdef MULDIV_DIV_EN
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        chk("div_lat", 64'(n), 64'd33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        issue(3'd2, 32'd7, 32'd0);
        wait_done(n);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'd7);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);
`else
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv_busy", busy, 1'b0);
        chk("nodiv_lo",   lo,   32'hFFFF_FFF1);
        repeat (3) @(posedge clk);
        #2;
`endif

        // MTHI while busy is ignored; back-to-back accept in the done cycle
        issue(3'd0, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        #2;
        issue(3'd4, 32'hAA, 32'd0);
        wait_done(n);
        chk("busy_mthi_hi", hi, 32'd0);
        chk("busy_mthi_lo", lo, 32'd63);
        #1;
        issue(3'd0, 32'd2, 32'd3);
        wait_done(n);
        chk("b2b_lat", 64'(n), 64'd33);
        chk("b2b_lo",  lo, 32'd6);

        // WIDTH=8 instance
        start8 = 1'b1; op8 = 3'd0; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #2 start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (done8) break;
        end
        chk("w8_lat", 64'(n), 64'd9);
        chk("w8_hi",  hi8, 8'hFE);
        chk("w8_lo",  lo8, 8'h01);
        #1;

        // Randomised traffic with stray starts while busy
        for (int i = 0; i < 300; i++) begin
            issue(3'($urandom_range(0, 7)), pick(), pick());
            n = 0;
            while (busy && n < 60) begin
                @(posedge clk);
                #2;
                if ($urandom_range(0, 9) == 0) begin
                    start = 1'b1; op = 3'($urandom_range(0, 7)); a = pick(); b = pick();
                end else begin
                    start = 1'b0;
                end
                n++;
            end
            start = 1'b0;
            if (n >= 60) chk("idle_timeout", 64'(n), 64'd0);
        end

        repeat (40) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
